// File: rtl/instr_encoder.sv
// instr_encoder: turns field-level RV32I instruction descriptions into encoded
// 32-bit words. Each emitted word carries its instruction-memory byte address.
// Illegal field combinations are accepted, dropped and counted.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          DEPTH     = 256,
    parameter int          ERR_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_fmt,
    input  logic [2:0]       in_func3,
    input  logic             in_alt,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_addr,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int IDX_W   = $clog2(DEPTH);
    localparam int NUM_FMT = 9;

    // Format codes
    localparam logic [3:0] FMT_R      = 4'd0;
    localparam logic [3:0] FMT_IALU   = 4'd1;
    localparam logic [3:0] FMT_LOAD   = 4'd2;
    localparam logic [3:0] FMT_STORE  = 4'd3;
    localparam logic [3:0] FMT_BRANCH = 4'd4;
    localparam logic [3:0] FMT_JAL    = 4'd5;
    localparam logic [3:0] FMT_JALR   = 4'd6;
    localparam logic [3:0] FMT_LUI    = 4'd7;
    localparam logic [3:0] FMT_AUIPC  = 4'd8;

    // Major opcodes
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Registered state
    logic             out_valid_reg, out_valid_next;
    logic [31:0]      out_instr_reg, out_instr_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             err_reg, err_next;
    logic [ERR_W-1:0] err_cnt_reg, err_cnt_next;

    // Decode / encode intermediates
    logic [NUM_FMT-1:0] fmt_hot;
    logic [NUM_FMT-1:0] fmt_ok;
    logic               legal;
    logic [31:0]        enc_word;
    logic               fits12, fits13, fits21;
    logic               is_shift;
    logic [6:0]         funct7_alt;
    logic               accept;
    logic               out_hs;

    // One-hot decode of the format code; codes 9-15 decode to no bit at all
    for (genvar gi = 0; gi < NUM_FMT; gi++) begin : g_fmt_hot
        assign fmt_hot[gi] = (in_fmt == 4'(gi));
    end

    // Immediate range checks: a value fits signed N bits when bits [31:N-1] all match
    always_comb begin
        fits12     = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
        fits13     = (in_imm[31:12] == '0) || (in_imm[31:12] == '1);
        fits21     = (in_imm[31:20] == '0) || (in_imm[31:20] == '1);
        is_shift   = (in_func3 == 3'b001) || (in_func3 == 3'b101);
        funct7_alt = in_alt ? 7'b0100000 : 7'b0000000;
    end

    // Per-format legality of the field combination
    always_comb begin
        fmt_ok = '0;
        fmt_ok[FMT_R]      = !in_alt || (in_func3 == 3'b000) || (in_func3 == 3'b101);
        fmt_ok[FMT_IALU]   = is_shift ? ((in_imm[31:5] == '0) && !((in_func3 == 3'b001) && in_alt))
                                      : fits12;
        fmt_ok[FMT_LOAD]   = (in_func3 != 3'b011) && (in_func3 != 3'b110) &&
                             (in_func3 != 3'b111) && fits12;
        fmt_ok[FMT_STORE]  = (in_func3 <= 3'b010) && fits12;
        fmt_ok[FMT_BRANCH] = (in_func3 != 3'b010) && (in_func3 != 3'b011) &&
                             !in_imm[0] && fits13;
        fmt_ok[FMT_JAL]    = !in_imm[0] && fits21;
        fmt_ok[FMT_JALR]   = (in_func3 == 3'b000) && fits12;
        fmt_ok[FMT_LUI]    = (in_imm[11:0] == '0);
        fmt_ok[FMT_AUIPC]  = (in_imm[11:0] == '0);
        legal = |(fmt_hot & fmt_ok);
    end

    // Bit-field assembly of the instruction word for each format
    always_comb begin
        enc_word = '0;
        case (in_fmt)
            FMT_R:      enc_word = {funct7_alt, in_rs2, in_rs1, in_func3, in_rd, OP_R};
            FMT_IALU: begin
                if (is_shift)
                    enc_word = {funct7_alt, in_imm[4:0], in_rs1, in_func3, in_rd, OP_IALU};
                else
                    enc_word = {in_imm[11:0], in_rs1, in_func3, in_rd, OP_IALU};
            end
            FMT_LOAD:   enc_word = {in_imm[11:0], in_rs1, in_func3, in_rd, OP_LOAD};
            FMT_STORE:  enc_word = {in_imm[11:5], in_rs2, in_rs1, in_func3, in_imm[4:0], OP_STORE};
            FMT_BRANCH: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_func3,
                                    in_imm[4:1], in_imm[11], OP_BRANCH};
            FMT_JAL:    enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                                    in_rd, OP_JAL};
            FMT_JALR:   enc_word = {in_imm[11:0], in_rs1, in_func3, in_rd, OP_JALR};
            FMT_LUI:    enc_word = {in_imm[31:12], in_rd, OP_LUI};
            FMT_AUIPC:  enc_word = {in_imm[31:12], in_rd, OP_AUIPC};
            default:    enc_word = '0;
        endcase
    end

    // Handshake and next-state: a new legal word may replace one leaving the same cycle
    always_comb begin
        in_ready       = !out_valid_reg || out_ready;
        accept         = in_valid && in_ready;
        out_hs         = out_valid_reg && out_ready;
        out_valid_next = out_valid_reg;
        out_instr_next = out_instr_reg;
        idx_next       = idx_reg;
        err_next       = accept && !legal;
        err_cnt_next   = err_cnt_reg;
        if (out_hs)
            idx_next = idx_reg + 1'b1;
        if (accept && legal) begin
            out_valid_next = 1'b1;
            out_instr_next = enc_word;
        end else if (out_hs) begin
            out_valid_next = 1'b0;
        end
        if (accept && !legal && (err_cnt_reg != '1))
            err_cnt_next = err_cnt_reg + 1'b1;
    end

    // State registers; reset drops any held word and restarts addressing
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_instr_reg <= '0;
            idx_reg       <= '0;
            err_reg       <= 1'b0;
            err_cnt_reg   <= '0;
        end else begin
            out_valid_reg <= out_valid_next;
            out_instr_reg <= out_instr_next;
            idx_reg       <= idx_next;
            err_reg       <= err_next;
            err_cnt_reg   <= err_cnt_next;
        end
    end

    // Word index wraps naturally at DEPTH (power of two); address is byte-granular
    assign out_valid = out_valid_reg;
    assign out_instr = out_instr_reg;
    assign out_addr  = BASE_ADDR + (32'(idx_reg) << 2);
    assign err       = err_reg;
    assign err_cnt   = err_cnt_reg;

endmodule
